// File: rtl/cpu_wb_pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor for the CPU writeback path.
// Each stage resolves one BLK_WID-bit block and hands its carry to the next stage.
module cpu_wb_pipe_cla_adder #(
   parameter int DATA_WID = 32,
   parameter int BLK_WID  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_WID-1:0] in1,
   input  logic [DATA_WID-1:0] in2,
   input  logic                carry_in,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_WID-1:0] sum,
   output logic                carry_out,
   output logic                overflow
);
   localparam int NUM_STG = DATA_WID / BLK_WID;

   if ((BLK_WID < 1) || (DATA_WID < BLK_WID) || ((DATA_WID % BLK_WID) != 0)) begin : g_bad_cfg
      $error("cpu_wb_pipe_cla_adder: DATA_WID must be a non-zero multiple of BLK_WID");
   end

   // One block of carry lookahead: every carry is formed from the block carry-in
   // through the running group generate/propagate terms. Returns {carry_out, sum}.
   function automatic logic [BLK_WID:0] cla_blk(
      input logic [BLK_WID-1:0] a,
      input logic [BLK_WID-1:0] b,
      input logic               cin
   );
      logic [BLK_WID-1:0] g;
      logic [BLK_WID-1:0] p;
      logic [BLK_WID:0]   c;
      logic               grp_g;
      logic               grp_p;
      g     = a & b;
      p     = a ^ b;
      c     = {(BLK_WID+1){1'b0}};
      c[0]  = cin;
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < BLK_WID; i++) begin
         grp_g    = g[i] | (p[i] & grp_g);
         grp_p    = grp_p & p[i];
         c[i+1]   = grp_g | (grp_p & cin);
      end
      return {c[BLK_WID], p ^ c[BLK_WID-1:0]};
   endfunction

   logic                stall_s;
   logic [DATA_WID-1:0] b_eff_s;
   logic                c0_s;

   assign stall_s  = out_valid & ~out_ready;
   assign in_ready = ~stall_s;
   // Subtract is A + ~B + ~borrow_in, so both B and the carry are inverted by sub.
   assign b_eff_s  = in2 ^ {DATA_WID{sub}};
   assign c0_s     = carry_in ^ sub;

   for (genvar k = 0; k < NUM_STG; k++) begin : gen_stg
      localparam int OPN_W   = DATA_WID - k*BLK_WID;
      localparam int SUM_W   = (k+1)*BLK_WID;
      localparam bit IS_LAST = (k == NUM_STG-1);

      logic             prv_vld_s;
      logic [OPN_W-1:0] a_s;
      logic [OPN_W-1:0] b_s;
      logic             cin_s;
      logic [BLK_WID:0] blk_s;
      logic [SUM_W-1:0] sum_nxt_s;
      logic             upd_s;
      logic             vld_r;
      logic [SUM_W-1:0] sum_r;
      logic             cy_r;

      if (k == 0) begin : g_src
         assign prv_vld_s = in_valid;
         assign a_s       = in1;
         assign b_s       = b_eff_s;
         assign cin_s     = c0_s;
         assign sum_nxt_s = blk_s[BLK_WID-1:0];
      end else begin : g_src
         assign prv_vld_s = gen_stg[k-1].vld_r;
         assign a_s       = gen_stg[k-1].g_up.a_r;
         assign b_s       = gen_stg[k-1].g_up.b_r;
         assign cin_s     = gen_stg[k-1].cy_r;
         assign sum_nxt_s = {blk_s[BLK_WID-1:0], gen_stg[k-1].sum_r};
      end

      assign blk_s = cla_blk(a_s[BLK_WID-1:0], b_s[BLK_WID-1:0], cin_s);
      // The last stage is the output register: it only loads when a real bundle arrives.
      assign upd_s = IS_LAST ? (prv_vld_s & ~stall_s & ~flush) : ~stall_s;

      // Stage valid bit: flush wins over stall, bubbles shift when not stalled
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_r <= 1'b0;
         end else if (flush) begin
            vld_r <= 1'b0;
         end else if (!stall_s) begin
            vld_r <= prv_vld_s;
         end else begin
            vld_r <= vld_r;
         end
      end

      // Resolved low result bits plus this block's carry-out
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_r <= {SUM_W{1'b0}};
            cy_r  <= 1'b0;
         end else if (upd_s) begin
            sum_r <= sum_nxt_s;
            cy_r  <= blk_s[BLK_WID];
         end else begin
            sum_r <= sum_r;
            cy_r  <= cy_r;
         end
      end

      if (!IS_LAST) begin : g_up
         logic [OPN_W-BLK_WID-1:0] a_r;
         logic [OPN_W-BLK_WID-1:0] b_r;

         // Operand bits still waiting for a later stage
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_r <= {(OPN_W-BLK_WID){1'b0}};
               b_r <= {(OPN_W-BLK_WID){1'b0}};
            end else if (upd_s) begin
               a_r <= a_s[OPN_W-1:BLK_WID];
               b_r <= b_s[OPN_W-1:BLK_WID];
            end else begin
               a_r <= a_r;
               b_r <= b_r;
            end
         end
      end else begin : g_last
         logic ovf_r;

         // Carry into the MSB is recovered as sum ^ a ^ b at that bit
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_r <= 1'b0;
            end else if (upd_s) begin
               ovf_r <= blk_s[BLK_WID] ^ blk_s[BLK_WID-1] ^ a_s[BLK_WID-1] ^ b_s[BLK_WID-1];
            end else begin
               ovf_r <= ovf_r;
            end
         end
      end
   end

   assign out_valid = gen_stg[NUM_STG-1].vld_r;
   assign sum       = gen_stg[NUM_STG-1].sum_r;
   assign carry_out = gen_stg[NUM_STG-1].cy_r;
   assign overflow  = gen_stg[NUM_STG-1].g_last.ovf_r;

endmodule

// File: tb/tb_cpu_wb_pipe_cla_adder.sv
// Self-checking bench for cpu_wb_pipe_cla_adder: directed cases, random streaming
// against an arithmetic reference model, flush, async reset and parameter sweep.
module tb_cpu_wb_pipe_cla_adder;
   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        carry_in;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        carry_out;
   logic        overflow;

   logic        w1_in_valid, w1_in_ready, w1_out_valid, w1_carry_out, w1_overflow;
   logic [31:0] w1_in1, w1_in2, w1_sum;
   logic        w2_in_valid, w2_in_ready, w2_out_valid, w2_carry_out, w2_overflow;
   logic [63:0] w2_in1, w2_in2, w2_sum;
   logic        w_out_ready;

   int n_cmp;
   int n_fail;
   logic [33:0] expq[$];

   cpu_wb_pipe_cla_adder #(.DATA_WID(32), .BLK_WID(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .carry_in(carry_in), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .overflow(overflow));

   cpu_wb_pipe_cla_adder #(.DATA_WID(32), .BLK_WID(32)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
      .in1(w1_in1), .in2(w1_in2), .carry_in(1'b0), .sub(1'b0), .out_valid(w1_out_valid),
      .out_ready(w_out_ready), .sum(w1_sum), .carry_out(w1_carry_out), .overflow(w1_overflow));

   cpu_wb_pipe_cla_adder #(.DATA_WID(64), .BLK_WID(16)) dut_w2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(w2_in_valid), .in_ready(w2_in_ready),
      .in1(w2_in1), .in2(w2_in2), .carry_in(1'b0), .sub(1'b0), .out_valid(w2_out_valid),
      .out_ready(w_out_ready), .sum(w2_sum), .carry_out(w2_carry_out), .overflow(w2_overflow));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {overflow, carry_out, sum} from plain integer arithmetic.
   function automatic logic [33:0] ref_op(logic [31:0] a, logic [31:0] b, logic ci, logic s);
      longint unsigned ua, ub, r;
      longint sa, sb, sr;
      logic co, ov;
      ua = a; ub = b;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!s) begin
         r  = ua + ub + ci;
         co = (ua + ub + ci) > 64'd4294967295;
         sr = sa + sb + ci;
      end else begin
         r  = ua - ub - ci;
         co = (ua >= ub + ci);
         sr = sa - sb - ci;
      end
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {ov, co, r[31:0]};
   endfunction

   task automatic run_op(string nm, logic [31:0] a, logic [31:0] b, logic ci, logic s,
                         logic [31:0] es, logic eco, logic eov);
      int lat;
      @(negedge clk);
      in1 = a; in2 = b; carry_in = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL %s_latency: got %0d expected 4", nm, lat); end
      n_cmp++; if (sum !== es) begin n_fail++; $display("FAIL %s_sum: got %h expected %h", nm, sum, es); end
      n_cmp++; if (carry_out !== eco) begin n_fail++; $display("FAIL %s_cout: got %b expected %b", nm, carry_out, eco); end
      n_cmp++; if (overflow !== eov) begin n_fail++; $display("FAIL %s_ovf: got %b expected %b", nm, overflow, eov); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in1 = 32'd0; in2 = 32'd0;
      carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
      w1_in_valid = 1'b0; w1_in1 = 32'd0; w1_in2 = 32'd0;
      w2_in_valid = 1'b0; w2_in1 = 64'd0; w2_in2 = 64'd0; w_out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
      n_cmp++; if (sum !== 32'd0) begin n_fail++; $display("FAIL rst_sum: got %h expected 0", sum); end
      n_cmp++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL rst_cout: got %b expected 0", carry_out); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_op("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("sub_bin", 32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
      run_op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_op("cross_blk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
   endtask

   task automatic test_stream();
      int issued;
      logic stall_prev;
      logic [33:0] snap, e, r;
      logic [31:0] a, b;
      logic ci, s;
      issued = 0; stall_prev = 1'b0; snap = 34'd0;
      for (int cyc = 0; cyc < 300 && (issued < 16 || expq.size() > 0); cyc++) begin
         @(negedge clk);
         if (stall_prev) begin
            n_cmp++;
            if ({out_valid, overflow, carry_out, sum} !== {1'b1, snap}) begin
               n_fail++;
               $display("FAIL stall_hold: got %b_%h expected 1_%h", out_valid, {overflow, carry_out, sum}, snap);
            end
         end
         out_ready = ($urandom_range(0, 2) != 0);
         a = $urandom; b = $urandom; ci = $urandom_range(0, 1); s = $urandom_range(0, 1);
         if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF - a;
         in1 = a; in2 = b; carry_in = ci; sub = s;
         in_valid = (issued < 16);
         #1;
         n_cmp++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            n_fail++;
            $display("FAIL stream_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (expq.size() == 0) begin
               n_fail++;
               $display("FAIL stream_extra: got %h expected no result", {overflow, carry_out, sum});
            end else begin
               e = expq.pop_front();
               if ({overflow, carry_out, sum} !== e) begin
                  n_fail++;
                  $display("FAIL stream_result: got %h expected %h", {overflow, carry_out, sum}, e);
               end
            end
         end
         stall_prev = out_valid && !out_ready;
         snap = {overflow, carry_out, sum};
         if (in_valid && in_ready) begin
            r = ref_op(a, b, ci, s);
            expq.push_back(r);
            issued++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++;
      if (expq.size() != 0 || issued != 16) begin
         n_fail++;
         $display("FAIL stream_drain: got issued=%0d left=%0d expected issued=16 left=0", issued, expq.size());
      end
      expq.delete();
   endtask

   task automatic test_flush();
      logic seen;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in1 = 32'h0000_0100 * (i + 1); in2 = 32'd1; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pre: got %b expected 0", out_valid); end
      flush = 1'b1; in1 = 32'h0000_DEAD; in_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_next: got %b expected 0", out_valid); end
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_leak: got %b expected 0", seen); end
      run_op("post_flush", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      logic seen;
      @(negedge clk);
      out_ready = 1'b0;
      in1 = 32'hC000_0000; in2 = 32'h8000_0001; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({out_valid, overflow, carry_out, sum} !== {3'b111, 32'h4000_0001}) begin
         n_fail++;
         $display("FAIL prereset_stall: got %b_%h expected 111_40000001", {out_valid, overflow, carry_out}, sum);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
      n_cmp++; if (sum !== 32'd0) begin n_fail++; $display("FAIL arst_sum: got %h expected 0", sum); end
      n_cmp++; if ({carry_out, overflow} !== 2'b00) begin n_fail++; $display("FAIL arst_flags: got %b expected 00", {carry_out, overflow}); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b expected 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL arst_leak: got %b expected 0", seen); end
      run_op("post_reset", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
   endtask

   task automatic test_sweep();
      int lat;
      @(negedge clk);
      w1_in1 = 32'hFFFF_FFFF; w1_in2 = 32'd1; w1_in_valid = 1'b1;
      @(negedge clk);
      w1_in_valid = 1'b0;
      lat = 1;
      while (!w1_out_valid && lat < 12) begin @(negedge clk); lat++; end
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL w1_latency: got %0d expected 1", lat); end
      n_cmp++; if ({w1_carry_out, w1_sum} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL w1_result: got %b_%h expected 1_00000000", w1_carry_out, w1_sum); end
      @(negedge clk);
      w2_in1 = 64'hFFFF_FFFF_FFFF_FFFF; w2_in2 = 64'd1; w2_in_valid = 1'b1;
      @(negedge clk);
      w2_in_valid = 1'b0;
      lat = 1;
      while (!w2_out_valid && lat < 12) begin @(negedge clk); lat++; end
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL w2_latency: got %0d expected 4", lat); end
      n_cmp++; if ({w2_carry_out, w2_overflow, w2_sum} !== {2'b10, 64'd0}) begin n_fail++; $display("FAIL w2_result: got %b_%h expected 10_0", {w2_carry_out, w2_overflow}, w2_sum); end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_directed();
      test_stream();
      test_flush();
      test_async_reset();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
